// File: rtl/product_accumulator_if.sv
// Stream bundle for product_accumulator: sample input channel, frame-sum output channel,
// plus a debug view of the FSM state.
interface product_accumulator_if #(
  parameter int N = 16
);
  // Both channels use valid/ready. A transfer happens on a rising edge where valid & ready
  // are both 1. While valid is 1 and ready is 0, the producer holds its data stable.
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sat;
  logic         dbg_hold;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sat, dbg_hold
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sat, dbg_hold
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums TAPS sign-magnitude Q1.15 products into one frame sum.
// The frame sum is converted back to saturated sign-magnitude and held until it is accepted.
module product_accumulator #(
  parameter int N    = 16,
  parameter int TAPS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  bus
);
  localparam int CNT_W = $clog2(TAPS);
  localparam int ACC_W = N + CNT_W;
  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] MAX_POS  = ACC_W'((2 ** (N - 1)) - 1);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [N-1:0]             out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  logic        [ACC_W-1:0]  sample_mag;
  logic signed [ACC_W-1:0]  sample_tc;
  logic signed [ACC_W-1:0]  sum;
  logic        [N-1:0]      sum_data;
  logic                     sum_sat;

  // Negative zero needs no special case: negating a zero magnitude still gives 0.
  always_comb begin
    sample_mag = {{(ACC_W - N + 1){1'b0}}, bus.in_data[N-2:0]};
    sample_tc  = bus.in_data[N-1] ? -sample_mag : sample_mag;
    sum        = acc_q + sample_tc;
    if (sum > MAX_POS) begin
      sum_data = {1'b0, {(N-1){1'b1}}};
      sum_sat  = 1'b1;
    end else if (sum < -MAX_POS) begin
      sum_data = '1;
      sum_sat  = 1'b1;
    end else begin
      sum_data = {sum[ACC_W-1], sum[ACC_W-1] ? (N-1)'(-sum) : sum[N-2:0]};
      sum_sat  = 1'b0;
    end
  end

  // The final sample is folded straight into the output register. Accumulator and counter
  // are left as they are until the output accept clears them.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      ACCUM: begin
        if (bus.in_valid) begin
          if (cnt_q == LAST_CNT) begin
            state_d    = HOLD;
            out_data_d = sum_data;
            out_sat_d  = sum_sat;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.dbg_hold  = (state_q == HOLD);
endmodule

// File: tb/tb_product_accumulator.sv
// Directed and randomized frames for product_accumulator, checked against an arithmetic
// model of the frame sum and its saturated sign-magnitude encoding.
module tb_product_accumulator;
  localparam int N    = 16;
  localparam int TAPS = 8;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic [N:0]   exp_q[$];
  logic [N-1:0] frame[TAPS];

  product_accumulator_if #(.N(N)) bus ();

  product_accumulator #(.N(N), .TAPS(TAPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {sat, data} for the frame currently in 'frame'.
  function automatic logic [N:0] model_frame();
    int sum = 0;
    for (int i = 0; i < TAPS; i++) begin
      int mag = int'(frame[i][N-2:0]);
      sum += frame[i][N-1] ? -mag : mag;
    end
    if (sum > 32767)  return {1'b1, 16'h7FFF};
    if (sum < -32767) return {1'b1, 16'hFFFF};
    if (sum < 0)      return {1'b0, 1'b1, 15'(-sum)};
    return {1'b0, 1'b0, 15'(sum)};
  endfunction

  task automatic fill(input logic [N-1:0] v);
    for (int i = 0; i < TAPS; i++) frame[i] = v;
  endtask

  task automatic drive_sample(input logic [N-1:0] d, input int gap_max);
    repeat ($urandom_range(0, gap_max)) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = N'($urandom);
    end
    @(negedge clk);
    check("in_ready_accum", bus.in_ready, 1);
    check("out_valid_accum", bus.out_valid, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
  endtask

  task automatic feed_frame(input int gap_max);
    for (int i = 0; i < TAPS; i++) drive_sample(frame[i], gap_max);
  endtask

  task automatic finish_frame(input int hold);
    logic [N:0] exp;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("out_valid_latency", bus.out_valid, 1);
    check("in_ready_hold", bus.in_ready, 0);
    check("exp_q_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("out_data", bus.out_data, exp[N-1:0]);
    check("out_sat", bus.out_sat, exp[N]);
    repeat (hold) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'h7FFF;
      @(negedge clk);
      check("hold_out_data", bus.out_data, exp[N-1:0]);
      check("hold_out_sat", bus.out_sat, exp[N]);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_out_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_accept_out_valid", bus.out_valid, 0);
    check("post_accept_in_ready", bus.in_ready, 1);
  endtask

  task automatic run_frame(input int gap_max, input int hold);
    exp_q.push_back(model_frame());
    feed_frame(gap_max);
    finish_frame(hold);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1000;
    bus.out_ready = 1'b0;

    // Reset with in_valid held high
    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 16'h0000);
      check("rst_out_sat", bus.out_sat, 0);
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_release_in_ready", bus.in_ready, 1);

    // Basic sum, back to back
    for (int i = 0; i < TAPS; i++) frame[i] = (i < 4) ? 16'h1000 : 16'h0000;
    run_frame(0, 0);

    // Signed mix summing to zero, including negative zero
    frame[0] = 16'h4000; frame[1] = 16'hC000; frame[2] = 16'h2000; frame[3] = 16'hA000;
    frame[4] = 16'h8000; frame[5] = 16'h0000; frame[6] = 16'h0001; frame[7] = 16'h8001;
    run_frame(0, 0);
    fill(16'h8100);
    run_frame(1, 0);

    // Saturation both ways
    fill(16'h2000);
    run_frame(0, 1);
    fill(16'hC000);
    run_frame(0, 0);

    // Backpressure for 5 cycles with in_valid driven, then a fresh frame
    fill(16'h1000);
    run_frame(0, 5);
    fill(16'h0800);
    run_frame(0, 0);

    // Mid-frame reset discards the partial frame
    for (int i = 0; i < 3; i++) drive_sample(16'h7FFF, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    fill(16'h0400);
    run_frame(0, 0);

    // Reset while holding a result discards it
    fill(16'h1000);
    feed_frame(0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("holdrst_pre_out_valid", bus.out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("holdrst_out_valid", bus.out_valid, 0);
    check("holdrst_out_data", bus.out_data, 16'h0000);
    check("holdrst_in_ready", bus.in_ready, 1);

    // Randomized frames: alternately small magnitudes and full-range samples
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < TAPS; i++) begin
        if (f % 2 == 0) frame[i] = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 4095))};
        else            frame[i] = N'($urandom);
      end
      run_frame(2, $urandom_range(0, 3));
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001: Parameter N, default 16: sample width; sign-magnitude Q1.15, bit N-1 = sign, bits N-2:0 = magnitude.
REQ-002: Parameter TAPS, default 8: products summed per output frame; legal range 2..64.
REQ-003: Timing is fixed: one clock; reset is synchronous and active-high. The ports are clk and rst.
REQ-004: clk  input  1  rising-edge clock for all state.
REQ-005: rst  input  1  synchronous active-high reset.
REQ-006: in_data  input  N  sign-magnitude Q1.15 product from the upstream multiplier.
REQ-007: in_valid  input  1  in_data valid this cycle.
REQ-008: in_ready  output  1  block accepts in_data this cycle.
REQ-009: out_data  output  N  sign-magnitude Q1.15 frame sum.
REQ-010: out_valid  output  1  out_data holds a complete frame sum.
REQ-011: out_ready  input  1  downstream accepts out_data this cycle.
REQ-012: out_sat  output  1  frame sum was clipped; qualified by out_valid.

Function
REQ-013: Input accept = in_valid & in_ready. Output accept = out_valid & out_ready.
REQ-014: FSM has two states: ACCUM and HOLD. in_ready = 1 in ACCUM and 0 in HOLD. out_valid = 1 in HOLD and 0 in ACCUM.
REQ-015: Each accepted sample is converted to two's complement.
- Sign 0: +magnitude.
- Sign 1: -magnitude.
- 0x8000 (negative zero) converts to 0.
REQ-016: Accumulator is two's complement, ACC_W = N + clog2(TAPS) bits wide. It never overflows internally; the maximum magnitude is TAPS*32767.
REQ-017: Tap counter is clog2(TAPS) bits wide. It increments on each input accept.
REQ-018: On the accept that brings the count to TAPS (the last sample of a frame), the block:
- registers the final sum (acc + converted sample) into out_data and out_sat;
- moves to HOLD.
out_valid is asserted on the next cycle, giving a latency of 1 cycle from the last accept.
REQ-019: Conversion of the final sum:
- sum > 32767: out_data = 0x7FFF, out_sat = 1.
- sum < -32767: out_data = 0xFFFF, out_sat = 1.
- otherwise: sign = (sum < 0), magnitude = |sum|, out_sat = 0.
REQ-020: A zero sum is output as 0x0000. Negative zero is never emitted.
REQ-021: In HOLD, out_data and out_sat stay stable until the output accept.
REQ-022: In HOLD, in_data and in_valid are ignored and the accumulator does not change.
REQ-023: On the output accept, the block clears the accumulator and tap counter and returns to ACCUM. in_ready = 1 in the following cycle.
REQ-024: A cycle with in_valid = 0 in ACCUM leaves the accumulator and counter unchanged. Gaps between samples are allowed.
REQ-025: Inputs and the handshake are sampled only on rising edges of clk.

Reset
REQ-026: While rst = 1 at a clock edge, the block sets: state ACCUM, accumulator 0, tap counter 0, out_data 0x0000, out_valid 0, out_sat 0.
REQ-027: in_ready reads 1 in the first cycle after rst deasserts.
REQ-028: rst overrides all simultaneous events. A partial frame or a held output is discarded without ever being emitted.

Verification
REQ-029: Reset check: assert rst for 2 cycles with in_valid = 1 -> out_valid = 0, out_data = 0x0000, out_sat = 0; in_ready = 1 after release.
REQ-030: Basic sum, TAPS = 8: feed 0x1000 x4, then 0x0000 x4, back to back -> exactly one cycle after the 8th accept, out_valid = 1, out_data = 0x4000, out_sat = 0.
REQ-031: Signed and negative-zero cases:
- Feed 0x4000, 0xC000, 0x2000, 0xA000, 0x8000, 0x0000, 0x0001, 0x8001 -> out_data = 0x0000, out_sat = 0.
- Feed 0x8100 x8 -> out_data = 0x8800.
REQ-032: Saturation:
- Feed 0x2000 x8 -> out_data = 0x7FFF, out_sat = 1.
- Feed 0xC000 x8 -> out_data = 0xFFFF, out_sat = 1.
REQ-033: Backpressure: complete a frame, hold out_ready = 0 for 5 cycles while driving in_valid = 1 with 0x7FFF -> during those cycles out_data is stable and in_ready = 0. After out_ready = 1, a fresh frame of 0x0800 x8 produces out_data = 0x4000.
REQ-034: Mid-frame reset: accept 3 samples of 0x7FFF, pulse rst for 1 cycle, then feed 0x0400 x8 -> a single output 0x2000, out_sat = 0, and no output from the aborted frame.
